// File: rtl/aes_seq_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES column sequencer.
package aes_seq_pkg;

    localparam int unsigned AES_COL_STEPS = 4;

    typedef logic [1:0] aes_col_step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_seq_state_e;

    // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Generic GF(2^8) multiply (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse as x^254 (x^2*x^4*...*x^128),
    // which maps 0 to 0, followed by the affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int unsigned i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_unit.sv
// Single-step AES encrypt-round column unit: selects byte bs_in of rs2_in,
// applies SubBytes and optionally the MixColumn contribution, rotates it
// into column position bs_in and XORs it into rs1_in. Purely combinational.
module aes_unit
    import aes_seq_pkg::*;
#(
    parameter int LOGIC_GATING = 0
) (
    input  logic        valid_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    input  logic [1:0]  bs_in,
    input  logic        mix_in,
    output logic [31:0] rd_out
);

    logic [31:0] w_rs1;
    logic [31:0] w_rs2;
    logic [7:0]  w_byte;
    logic [7:0]  w_sb;
    logic [7:0]  w_x2;
    logic [7:0]  w_x3;
    logic [31:0] w_mixed;
    logic [31:0] w_rot;
    logic [31:0] w_rd;

    generate
        if (LOGIC_GATING != 0) begin : g_gate
            // Operands forced to zero when idle so the S-box logic does not toggle.
            assign w_rs1  = valid_in ? rs1_in : '0;
            assign w_rs2  = valid_in ? rs2_in : '0;
            assign rd_out = valid_in ? w_rd : '0;
        end else begin : g_nogate
            logic w_unused_valid;
            assign w_unused_valid = valid_in;
            assign w_rs1  = rs1_in;
            assign w_rs2  = rs2_in;
            assign rd_out = w_rd;
        end
    endgenerate

    assign w_byte = w_rs2[{bs_in, 3'b000} +: 8];
    assign w_sb   = aes_sbox(w_byte);
    assign w_x2   = gf_xtime(w_sb);
    assign w_x3   = w_x2 ^ w_sb;

    // Column contribution {3s, s, s, 2s} or {0, 0, 0, s}, rotated left by 8*bs.
    always_comb begin
        w_mixed = mix_in ? {w_x3, w_sb, w_sb, w_x2} : {24'h000000, w_sb};
        case (bs_in)
            2'd0:    w_rot = w_mixed;
            2'd1:    w_rot = {w_mixed[23:0], w_mixed[31:24]};
            2'd2:    w_rot = {w_mixed[15:0], w_mixed[31:16]};
            default: w_rot = {w_mixed[7:0],  w_mixed[31:8]};
        endcase
        w_rd = w_rs1 ^ w_rot;
    end

endmodule

// File: rtl/aes_col_seq.sv
// AES column sequencer: accepts a round-key word and four state words,
// runs the four byte-select steps through aes_unit back-to-back with the
// accumulator fed back as rs1, and returns the column on a valid/ready port.
module aes_col_seq
    import aes_seq_pkg::*;
#(
    parameter int LOGIC_GATING = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_in,
    output logic         req_ready_out,
    input  logic [31:0]  key_in,
    input  logic [127:0] src_in,
    input  logic         mix_in,
    input  logic         flush_in,
    output logic         resp_valid_out,
    input  logic         resp_ready_in,
    output logic [31:0]  result_out,
    output logic         busy_out
);

    localparam aes_col_step_t LAST_STEP = aes_col_step_t'(AES_COL_STEPS - 1);

    aes_seq_state_e          r_state;
    aes_seq_state_e          w_state_nxt;
    logic [31:0]             r_acc;
    logic [32*AES_COL_STEPS-1:0] r_src;
    logic                    r_mix;
    aes_col_step_t           r_cnt;

    logic                    w_req_ready;
    logic                    w_accept;
    logic                    w_unit_valid;
    logic [31:0]             w_rs2;
    logic [31:0]             w_rd;

    // A response handshake in DONE frees the slot in the same cycle; flush blocks acceptance.
    assign w_req_ready  = !flush_in &&
                          ((r_state == IDLE) || ((r_state == DONE) && resp_ready_in));
    assign w_accept     = req_valid_in && w_req_ready;
    assign w_unit_valid = (r_state == BUSY);
    assign w_rs2        = r_src[{r_cnt, 5'b00000} +: 32];

    assign req_ready_out  = w_req_ready;
    assign resp_valid_out = (r_state == DONE);
    assign result_out     = r_acc;
    assign busy_out       = (r_state == BUSY) || (r_state == DONE);

    aes_unit #(
        .LOGIC_GATING (LOGIC_GATING)
    ) i_aes_unit (
        .valid_in (w_unit_valid),
        .rs1_in   (r_acc),
        .rs2_in   (w_rs2),
        .bs_in    (r_cnt),
        .mix_in   (r_mix),
        .rd_out   (w_rd)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_ready_in) begin
                    w_state_nxt = w_accept ? BUSY : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (flush_in) begin
            w_state_nxt = IDLE;
        end
    end

    // Operand capture on acceptance and accumulator/step update while BUSY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
            r_src <= '0;
            r_mix <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= key_in;
            r_src <= src_in;
            r_mix <= mix_in;
            r_cnt <= '0;
        end else if ((r_state == BUSY) && !flush_in) begin
            r_acc <= w_rd;
            r_cnt <= r_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_aes_col_seq.sv
// Scoreboard bench for aes_col_seq with an independent AES column model.
module tb_aes_col_seq;

    logic         clk_i;
    logic         rst_ni;
    logic         req_valid_in;
    logic         req_ready_out;
    logic [31:0]  key_in;
    logic [127:0] src_in;
    logic         mix_in;
    logic         flush_in;
    logic         resp_valid_out;
    logic         resp_ready_in;
    logic [31:0]  result_out;
    logic         busy_out;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [31:0]  sb[$];
    logic [31:0]  mon_exp;

    aes_col_seq #(
        .LOGIC_GATING (0)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .key_in         (key_in),
        .src_in         (src_in),
        .mix_in         (mix_in),
        .flush_in       (flush_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .result_out     (result_out),
        .busy_out       (busy_out)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] poly;
        p    = '0;
        poly = 15'h011B;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (poly << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = '0;
        c   = 8'h63;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++)
                if (m_mul(x, y[7:0]) == 8'h01) inv = y[7:0];
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] m_col(input logic [31:0] key, input logic [127:0] src,
                                          input logic mix);
        logic [31:0] acc;
        logic [31:0] w;
        logic [7:0]  s;
        acc = key;
        for (int i = 0; i < 4; i++) begin
            s = m_sbox(src[40*i +: 8]);
            w = mix ? {m_mul(s, 8'h03), s, s, m_mul(s, 8'h02)} : {24'h0, s};
            if (i != 0) w = (w << (8*i)) | (w >> (32 - 8*i));
            acc = acc ^ w;
        end
        return acc;
    endfunction

    // ---------------- response monitor ----------------
    always @(negedge clk_i) begin
        if (rst_ni && resp_valid_out && resp_ready_in) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                chk("result", result_out, mon_exp);
            end
        end
    end

    // ---------------- driver tasks (called #1 after a rising edge) ----------------
    task automatic send(input logic [31:0] key, input logic [127:0] src, input logic mix);
        logic rdy;
        logic ok;
        req_valid_in = 1'b1;
        key_in       = key;
        src_in       = src;
        mix_in       = mix;
        ok           = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            rdy = req_ready_out;
            @(posedge clk_i);
            if (rdy) begin
                sb.push_back(m_col(key, src, mix));
                ok = 1'b1;
            end
        end
        #1;
        req_valid_in = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        while (n < 20 && !resp_valid_out) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk(tag, n, 4);
    endtask

    task automatic run_one(input logic [31:0] key, input logic [127:0] src, input logic mix);
        send(key, src, mix);
        wait_resp("latency");
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_out), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid_out), 32'd0);
        chk({tag, "_result"}, result_out, 32'd0);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0]  k1;
        logic [127:0] s1;
        logic [31:0]  e1;
        logic [31:0]  k2;
        logic [127:0] s2;
        logic         seen;

        rst_ni        = 1'b0;
        req_valid_in  = 1'b0;
        key_in        = '0;
        src_in        = '0;
        mix_in        = 1'b0;
        flush_in      = 1'b0;
        resp_ready_in = 1'b1;
        #2;
        chk_reset_outputs("rst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed columns
        run_one(32'h0000_0000, 128'h0, 1'b1);
        run_one(32'hFFFF_FFFF, 128'h0, 1'b0);
        run_one(32'h0000_0000, 128'h0000_0053, 1'b0);
        run_one(32'h0000_0000, 128'h0000_5300, 1'b0);

        // Backpressure then back-to-back acceptance
        k1 = $urandom;
        s1 = {$urandom, $urandom, $urandom, $urandom};
        e1 = m_col(k1, s1, 1'b1);
        k2 = $urandom;
        s2 = {$urandom, $urandom, $urandom, $urandom};
        resp_ready_in = 1'b0;
        send(k1, s1, 1'b1);
        wait_resp("bp_latency");
        req_valid_in = 1'b1;
        key_in       = k2;
        src_in       = s2;
        mix_in       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(resp_valid_out), 32'd1);
            chk("bp_result", result_out, e1);
            chk("bp_req_ready", 32'(req_ready_out), 32'd0);
            @(posedge clk_i);
            #1;
        end
        resp_ready_in = 1'b1;
        #1;
        chk("b2b_req_ready", 32'(req_ready_out), 32'd1);
        @(posedge clk_i);
        sb.push_back(m_col(k2, s2, 1'b0));
        #1;
        req_valid_in = 1'b0;
        chk("b2b_busy", 32'(busy_out), 32'd1);
        chk("b2b_not_done", 32'(resp_valid_out), 32'd0);
        wait_resp("b2b_latency");
        @(posedge clk_i);
        #1;

        // Flush beats a simultaneous request in IDLE
        req_valid_in = 1'b1;
        flush_in     = 1'b1;
        #1;
        chk("flush_req_ready", 32'(req_ready_out), 32'd0);
        @(posedge clk_i);
        #1;
        flush_in     = 1'b0;
        req_valid_in = 1'b0;
        chk("flush_no_accept", 32'(busy_out), 32'd0);

        // Flush while cnt == 2
        send($urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        flush_in = 1'b1;
        @(posedge clk_i);
        #1;
        flush_in = 1'b0;
        void'(sb.pop_back());
        chk("flush_idle", 32'(busy_out), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid_out) seen = 1'b1;
            @(posedge clk_i);
            #1;
        end
        chk("flush_no_resp", 32'(seen), 32'd0);
        run_one(32'h0000_0000, 128'h0, 1'b1);

        // Reset in the middle of an operation
        send($urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        void'(sb.pop_back());
        chk_reset_outputs("midrst");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_one($urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

        // Random columns
        for (int i = 0; i < 8; i++)
            run_one($urandom, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));

        repeat (2) @(posedge clk_i);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
